// File: rtl/op_arbiter.sv
// ============================================================================
// Module   : op_arbiter
// Brief    : Round-robin arbiter sharing one single-cycle op unit among
//            NUM_REQ requesters, with a valid/ready response path.
//            Optional statistics counters: define OP_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int OP_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*2-1:0]          req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data2,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    op_sel,
    output logic [DATA_WIDTH-1:0]         op_data1,
    output logic [DATA_WIDTH-1:0]         op_data2,
    output logic                          op_data_valid,
    input  logic [DATA_WIDTH-1:0]         op_result,
    output logic                          busy
`ifdef OP_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_txn_count,
    output logic [31:0]                   stat_busy_cycles
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]     NUM_EXT  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0]   LAT_INIT = CNT_W'(OP_LATENCY);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        rr_ptr_d;
    logic [IDX_W-1:0]        gnt_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              op_sel_q;
    logic [DATA_WIDTH-1:0]   op_data1_q;
    logic [DATA_WIDTH-1:0]   op_data2_q;
    logic                    op_valid_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic                    gnt_found_w;
    logic [IDX_W-1:0]        gnt_idx_w;
    logic [IDX_W:0]          sum_w;

    // Scan offsets from farthest to nearest so the nearest requester to rr_ptr wins.
    always_comb begin
        gnt_found_w = 1'b0;
        gnt_idx_w   = '0;
        sum_w       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum_w = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (sum_w >= NUM_EXT) begin
                sum_w = sum_w - NUM_EXT;
            end
            if (req_valid[sum_w[IDX_W-1:0]]) begin
                gnt_found_w = 1'b1;
                gnt_idx_w   = sum_w[IDX_W-1:0];
            end
        end
    end

    assign rr_ptr_d  = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
    assign req_ready = (state_q == S_IDLE && gnt_found_w) ? (ONE_HOT0 << gnt_idx_w) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            op_sel_q    <= '0;
            op_data1_q  <= '0;
            op_data2_q  <= '0;
            op_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found_w) begin
                        gnt_q      <= gnt_idx_w;
                        op_sel_q   <= req_op[2*int'(gnt_idx_w) +: 2];
                        op_data1_q <= req_data1[DATA_WIDTH*int'(gnt_idx_w) +: DATA_WIDTH];
                        op_data2_q <= req_data2[DATA_WIDTH*int'(gnt_idx_w) +: DATA_WIDTH];
                        op_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    op_valid_q <= 1'b0;
                    cnt_q      <= LAT_INIT;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_data_q  <= op_result;
                        rsp_valid_q <= ONE_HOT0 << gnt_q;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid_q <= '0;
                        rsp_data_q  <= '0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign op_sel        = op_sel_q;
    assign op_data1      = op_data1_q;
    assign op_data2      = op_data2_q;
    assign op_data_valid = op_valid_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state_q != S_IDLE);

`ifdef OP_ARB_STATS_EN
    logic [31:0] txn_cnt_q;
    logic [31:0] busy_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (state_q == S_RESP && rsp_ready[gnt_q]) begin
                txn_cnt_q <= txn_cnt_q + 32'd1;
            end
            if (busy) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
        end
    end

    assign stat_txn_count   = txn_cnt_q;
    assign stat_busy_cycles = busy_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_op_arbiter.sv
// ============================================================================
// Module   : tb_op_arbiter
// Brief    : Directed self-checking bench for op_arbiter (OP_LATENCY 1 and 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_op_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    // Instance A: OP_LATENCY = 1
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*2-1:0]  req_op    = '0;
    logic [NR*DW-1:0] req_data1 = '0;
    logic [NR*DW-1:0] req_data2 = '0;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready = '1;
    logic [DW-1:0]    rsp_data;
    logic [1:0]       op_sel;
    logic [DW-1:0]    op_data1;
    logic [DW-1:0]    op_data2;
    logic             op_data_valid;
    logic [DW-1:0]    op_result;
    logic             busy;

    // Instance B: OP_LATENCY = 3
    logic [NR-1:0]    b_req_valid = '0;
    logic [NR-1:0]    b_req_ready;
    logic [NR*2-1:0]  b_req_op    = '0;
    logic [NR*DW-1:0] b_req_data1 = '0;
    logic [NR*DW-1:0] b_req_data2 = '0;
    logic [NR-1:0]    b_rsp_valid;
    logic [NR-1:0]    b_rsp_ready = '1;
    logic [DW-1:0]    b_rsp_data;
    logic [1:0]       b_op_sel;
    logic [DW-1:0]    b_op_data1;
    logic [DW-1:0]    b_op_data2;
    logic             b_op_data_valid;
    logic [DW-1:0]    b_op_result;
    logic             b_busy;

`ifdef OP_ARB_STATS_EN
    logic [31:0] stat_txn_count, stat_busy_cycles;
    logic [31:0] b_stat_txn_count, b_stat_busy_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] op_model(input logic [1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign op_result   = op_model(op_sel, op_data1, op_data2);
    assign b_op_result = op_model(b_op_sel, b_op_data1, b_op_data2);

    op_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .OP_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data1(req_data1), .req_data2(req_data2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .op_sel(op_sel), .op_data1(op_data1), .op_data2(op_data2),
        .op_data_valid(op_data_valid), .op_result(op_result), .busy(busy)
`ifdef OP_ARB_STATS_EN
        , .stat_txn_count(stat_txn_count), .stat_busy_cycles(stat_busy_cycles)
`endif
    );

    op_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .OP_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_data1(b_req_data1), .req_data2(b_req_data2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .op_sel(b_op_sel), .op_data1(b_op_data1), .op_data2(b_op_data2),
        .op_data_valid(b_op_data_valid), .op_result(b_op_result), .busy(b_busy)
`ifdef OP_ARB_STATS_EN
        , .stat_txn_count(b_stat_txn_count), .stat_busy_cycles(b_stat_busy_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a grant, check it, then take the accept edge.
    task automatic grant(input bit sel_b, input logic [NR-1:0] exp_rdy, input string tag);
        int n = 0;
        #1;
        while (((sel_b ? b_req_ready : req_ready) == '0) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(sel_b ? b_req_ready : req_ready), 64'(exp_rdy));
        tick();
    endtask

    // Wait (bounded) for the response and check latency, mask and data.
    task automatic response(input bit sel_b, input int exp_cycles, input logic [NR-1:0] exp_vld,
                            input logic [DW-1:0] exp_data, input string tag);
        int n = 0;
        while (((sel_b ? b_rsp_valid : rsp_valid) == '0) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_cycles));
        check({tag, "_vld"}, 64'(sel_b ? b_rsp_valid : rsp_valid), 64'(exp_vld));
        check({tag, "_data"}, 64'(sel_b ? b_rsp_data : rsp_data), 64'(exp_data));
    endtask

    task automatic set_a(input int i, input logic [1:0] op, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2);
        req_op[2*i +: 2]     = op;
        req_data1[DW*i +: DW] = d1;
        req_data2[DW*i +: DW] = d2;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_op_dv", 64'(op_data_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;

        // Single request: 5 + 7
        set_a(0, 2'd0, 32'd5, 32'd7);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("single_issue_dv", 64'(op_data_valid), 64'd1);
        check("single_issue_d1", 64'(op_data1), 64'd5);
        check("single_issue_rdy", 64'(req_ready), 64'd0);
        check("single_busy", 64'(busy), 64'd1);
        tick();
        check("single_wait_dv", 64'(op_data_valid), 64'd0);
        check("single_wait_rsp", 64'(rsp_valid), 64'd0);
        tick();
        check("single_rsp_vld", 64'(rsp_valid), 64'h1);
        check("single_rsp_data", 64'(rsp_data), 64'd12);
        tick();
        check("single_done_vld", 64'(rsp_valid), 64'd0);
        check("single_done_data", 64'(rsp_data), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);

        // Round robin from a fresh reset
        do_reset();
        for (int i = 0; i < NR; i++) set_a(i, 2'd0, 32'(10 * i + 1), 32'(100 + i));
        req_valid = 4'b1111;
        grant(1'b0, 4'b0001, "rr0"); response(1'b0, 2, 4'b0001, 32'd101, "rr0"); tick();
        grant(1'b0, 4'b0010, "rr1"); response(1'b0, 2, 4'b0010, 32'd112, "rr1"); tick();
        grant(1'b0, 4'b0100, "rr2"); response(1'b0, 2, 4'b0100, 32'd123, "rr2"); tick();
        grant(1'b0, 4'b1000, "rr3"); response(1'b0, 2, 4'b1000, 32'd134, "rr3"); tick();
        grant(1'b0, 4'b0001, "rr4"); response(1'b0, 2, 4'b0001, 32'd101, "rr4"); tick();

        // Backpressure on requester 2 (rr_ptr now 1); other rsp_ready lines are ignored
        req_valid = 4'b1100;
        rsp_ready = 4'b1011;
        grant(1'b0, 4'b0100, "bp");
        response(1'b0, 2, 4'b0100, 32'd123, "bp");
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_vld", 64'(rsp_valid), 64'h4);
            check("bp_hold_data", 64'(rsp_data), 64'd123);
            check("bp_hold_rdy", 64'(req_ready), 64'd0);
        end
        rsp_ready = 4'b1111;
        tick();
        check("bp_next_rdy", 64'(req_ready), 64'h8);
        grant(1'b0, 4'b1000, "bp3"); response(1'b0, 2, 4'b1000, 32'd134, "bp3"); tick();

        // Non-add opcode: 3 & 4
        set_a(0, 2'd1, 32'd3, 32'd4);
        req_valid = 4'b0001;
        grant(1'b0, 4'b0001, "and");
        response(1'b0, 2, 4'b0001, 32'd0, "and");
        tick();

        // Reset during WAIT (rr_ptr is 1 before the reset)
        req_valid = 4'b0010;
        grant(1'b0, 4'b0010, "mid");
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_op_d1", 64'(op_data1), 64'd0);
        check("mid_rst_op_dv", 64'(op_data_valid), 64'd0);
        check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mid_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_a(0, 2'd0, 32'd5, 32'd7);
        req_valid = 4'b1111;
        grant(1'b0, 4'b0001, "post_rst");
        req_valid = '0;
        response(1'b0, 2, 4'b0001, 32'd12, "post_rst");
        tick();

        // OP_LATENCY = 3 with pointer wrap-around
        b_req_op    = '0;
        b_req_data1 = {32'd0, 32'd2, 32'd40, 32'd9};
        b_req_data2 = {32'd0, 32'd3, 32'd2, 32'd1};
        b_req_valid = 4'b0100;
        grant(1'b1, 4'b0100, "l3a");
        b_req_valid = '0;
        response(1'b1, 4, 4'b0100, 32'd5, "l3a");
        tick();
        b_req_valid = 4'b0011;
        grant(1'b1, 4'b0001, "l3wrap");
        b_req_valid = '0;
        response(1'b1, 4, 4'b0001, 32'd10, "l3wrap");
        tick();
        check("l3_idle_busy", 64'(b_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
